// File: rtl/pw_switch_seq.sv
// pw_switch_seq: responder side of the power-gating switch handshake.
// Ramps N_SEG switch segments on/off one at a time with a programmable
// spacing of step_count+1 cycles, and acknowledges the request once the
// ramp has completed.
module pw_switch_seq #(
    parameter int unsigned N_SEG = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             en_pw_sw,
    input  logic [CNT_W-1:0] step_count,
    output logic [N_SEG-1:0] sw_en,
    output logic             sw_ack,
    output logic             busy
);

    localparam int unsigned IDX_W = $clog2(N_SEG + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_SEG);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ALL_ON,
        RAMP_DOWN,
        ALL_OFF,
        RAMP_UP
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_timer;
    logic             r_ack;
    logic             r_busy;
    logic [N_SEG-1:0] w_sw_en;

    // Sequencer: state, segment count, step timer and registered handshake outputs
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= ALL_ON;
            r_idx   <= IDX_FULL;
            r_timer <= '0;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ALL_ON: begin
                    if (en_pw_sw) begin
                        r_state <= RAMP_DOWN;
                        r_timer <= '0;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                RAMP_DOWN: begin
                    if (!en_pw_sw) begin
                        // Reversal: no segment moves on this edge
                        r_timer <= '0;
                        if (r_idx == IDX_FULL) begin
                            r_state <= ALL_ON;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= RAMP_UP;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end else if (r_timer >= step_count) begin
                        r_idx   <= r_idx - IDX_ONE;
                        r_timer <= '0;
                        if (r_idx == IDX_ONE) begin
                            r_state <= ALL_OFF;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end

                ALL_OFF: begin
                    if (!en_pw_sw) begin
                        r_state <= RAMP_UP;
                        r_timer <= '0;
                        r_ack   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                RAMP_UP: begin
                    if (en_pw_sw) begin
                        // Reversal: no segment moves on this edge
                        r_timer <= '0;
                        if (r_idx == '0) begin
                            r_state <= ALL_OFF;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= RAMP_DOWN;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end else if (r_timer >= step_count) begin
                        r_idx   <= r_idx + IDX_ONE;
                        r_timer <= '0;
                        if (r_idx == IDX_FULL - IDX_ONE) begin
                            r_state <= ALL_ON;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ALL_ON;
                    r_idx   <= IDX_FULL;
                    r_timer <= '0;
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Thermometer decode of the segment count: bit i conducts when i < idx
    always_comb begin
        w_sw_en = '0;
        for (int unsigned i = 0; i < N_SEG; i++) begin
            w_sw_en[i] = (IDX_W'(i) < r_idx);
        end
    end

    assign sw_en  = w_sw_en;
    assign sw_ack = r_ack;
    assign busy   = r_busy;

endmodule

// File: doc/pw_switch_seq.md
Name: pw_switch_seq

Overview:
- Responder side of the power-gating switch handshake: receives the switch-enable request `en_pw_sw` from the power-gating controller and returns `sw_ack`.
- Ramps a chain of N_SEG power-switch segments on or off one segment at a time, with a programmable spacing, to limit rush current.
- Sits between the controller and the switch cells of one gated domain, in the controller's clock domain.

Parameters:
- N_SEG, 8, number of switch segments (legal 2..32).
- CNT_W, 8, width of the step timer and of `step_count`.

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en_pw_sw  input  1  switch request: 1 = switches off (domain off), 0 = switches on. Sampled synchronously.
- step_count  input  CNT_W  number of extra cycles between segment toggles (spacing = step_count+1 cycles).
- sw_en  output  N_SEG  per-segment enable, 1 = segment conducting. Always thermometer code from bit 0.
- sw_ack  output  1  1 = domain fully on, or ramp-down not yet complete; 0 = domain fully off, or ramp-up not yet complete.
- busy  output  1  1 while ramping.

Behaviour:
- Registers:
  - `state` in {ALL_ON, RAMP_DOWN, ALL_OFF, RAMP_UP}.
  - `idx` = number of segments on, 0..N_SEG, width clog2(N_SEG+1).
  - `timer`, CNT_W bits.
  - `sw_en[i] = (i < idx)`, registered or derived combinationally from the `idx` register; no other decode is allowed.
- Reset (async, rst=1):
  - state=ALL_ON, idx=N_SEG, timer=0.
  - sw_en = all ones, sw_ack=1, busy=0.
  - Rationale: matches the controller's reset state, in which the domain is on.
- ALL_ON:
  - en_pw_sw=1 → RAMP_DOWN, timer←0, no segment change.
  - Otherwise hold.
- RAMP_DOWN:
  - If en_pw_sw=0 (reversal):
    - idx==N_SEG → ALL_ON.
    - Otherwise → RAMP_UP.
    - In both cases timer←0 and idx unchanged.
  - Else if timer ≥ step_count:
    - idx←idx−1, timer←0.
    - If the new idx==0 → ALL_OFF.
  - Else timer←timer+1.
- ALL_OFF:
  - en_pw_sw=0 → RAMP_UP, timer←0.
  - Otherwise hold.
- RAMP_UP: mirror of RAMP_DOWN.
  - If en_pw_sw=1 (reversal):
    - idx==0 → ALL_OFF.
    - Otherwise → RAMP_DOWN.
    - In both cases timer←0 and idx unchanged.
  - Else if timer ≥ step_count:
    - idx←idx+1, timer←0.
    - If the new idx==N_SEG → ALL_ON.
  - Else timer←timer+1.
- Outputs:
  - sw_ack registered: 1 in ALL_ON and RAMP_DOWN, 0 in ALL_OFF and RAMP_UP. It updates on the same edge as the state change.
  - Net effect: sw_ack falls on the edge the last segment opens and rises on the edge the last segment closes.
  - busy = 1 in RAMP_DOWN or RAMP_UP.
- Latency:
  - Call the edge that samples the new request edge 1.
  - The first toggle is at edge 1+(step_count+1).
  - The final toggle and the sw_ack change are at edge 1+N_SEG·(step_count+1).
- Timer rules:
  - `≥` comparison is used, so lowering `step_count` mid-ramp never overshoots or wraps; the new value takes effect on the next compare.
  - step_count=0 gives one segment per cycle.
- Each toggle changes exactly one sw_en bit. No bit ever toggles in the opposite direction of the current ramp.
- A reversal never toggles a segment on the reversal edge.
- rst mid-ramp: immediately all segments on, sw_ack=1. This is accepted behaviour because reset implies a domain restart.
- Steady `en_pw_sw` in ALL_ON or ALL_OFF causes no timer activity; timer is held at 0.

Test Plan:
- Reset release with en_pw_sw=0: sw_en=8'hFF, sw_ack=1, busy=0; stable for 50 cycles.
- Power-down, step_count=3, en_pw_sw 0→1 at edge 1:
  - sw_en goes FF→7F at edge 5, 7F→3F at edge 9, … reaching 00 at edge 33.
  - sw_ack stays 1 through edge 32 and is 0 after edge 33; busy falls at edge 33.
- Power-up from ALL_OFF, step_count=0: sw_en goes 01,03,07,…,FF on consecutive edges 2..9; sw_ack rises with FF at edge 9.
- Reversal, step_count=3: drop en_pw_sw to 0 when sw_en=3F.
  - sw_ack falls on the reversal edge.
  - No toggle on that edge; 7F appears 4 edges later, FF 8 edges later, then sw_ack=1.
- step_count lowered from 200 to 2 while timer=50: next segment toggles on the following edge, then every 3 edges after that.
- Async rst asserted mid ramp-down (sw_en=0F): sw_en=FF and sw_ack=1 immediately, without waiting for a clock edge; after release, state is ALL_ON.
